// File: rtl/char_block_decoder_pkg.sv
// rtl/char_block_decoder_pkg.sv - FSM states, class indices and whitespace bytes shared by the block decoder
package char_block_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOD,
        ST_STREAM,
        ST_DONE
    } state_e;

    localparam int CLS_NONE = -1;
    localparam int CLS_A    = 0;
    localparam int CLS_D    = 1;
    localparam int CLS_V    = 2;
    localparam int CLS_N    = 3;
    localparam int CLS_C    = 4;
    localparam int CLS_E    = 5;
    localparam int CLS_WS   = 6;
    localparam int CLS_S    = 7;
    localparam int CLS_P    = 8;
    localparam int CLS_Y    = 9;
    localparam int CLS_R    = 10;
    localparam int CLS_O    = 11;
    localparam int CLS_T    = 12;
    localparam int CLS_F    = 13;

    localparam logic [7:0] WS_SPACE = 8'h20;
    localparam logic [7:0] WS_TAB   = 8'h09;
    localparam logic [7:0] WS_LF    = 8'h0A;
    localparam logic [7:0] WS_VT    = 8'h0B;
    localparam logic [7:0] WS_FF    = 8'h0C;
    localparam logic [7:0] WS_CR    = 8'h0D;

    // Upper-case letters fold onto lower case so every letter class is case-insensitive.
    function automatic int class_of(input logic [7:0] b);
        logic [7:0] lc;
        lc = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
        case (lc)
            8'h61:   class_of = CLS_A;
            8'h64:   class_of = CLS_D;
            8'h76:   class_of = CLS_V;
            8'h6E:   class_of = CLS_N;
            8'h63:   class_of = CLS_C;
            8'h65:   class_of = CLS_E;
            8'h73:   class_of = CLS_S;
            8'h70:   class_of = CLS_P;
            8'h79:   class_of = CLS_Y;
            8'h72:   class_of = CLS_R;
            8'h6F:   class_of = CLS_O;
            8'h74:   class_of = CLS_T;
            8'h66:   class_of = CLS_F;
            WS_SPACE, WS_TAB, WS_LF, WS_VT, WS_FF, WS_CR:
                     class_of = CLS_WS;
            default: class_of = CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/char_class_rom.sv
// rtl/char_class_rom.sv - combinational byte to one-hot character-class decode
module char_class_rom
    import char_block_decoder_pkg::*;
#(
    parameter int NUM_CLASSES = 14
) (
    input  logic [7:0]             data,
    output logic [NUM_CLASSES-1:0] match
);

    int cls;

    // A byte maps to at most one class index, so the result is one-hot or zero by construction.
    always_comb begin
        cls = class_of(data);
        for (int k = 0; k < NUM_CLASSES; k++) begin
            match[k] = (cls == k);
        end
    end

endmodule

// File: rtl/char_block_decoder.sv
// rtl/char_block_decoder.sv - packet framing, skid buffer and step control in front of the match engine
module char_block_decoder
    import char_block_decoder_pkg::*;
#(
    parameter int NUM_CLASSES = 14,
    parameter int SKID_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_data,
    input  logic                   s_sop,
    input  logic                   s_eop,
    output logic                   sod,
    output logic                   en,
    output logic [NUM_CLASSES-1:0] char_match,
    output logic                   pkt_done,
    output logic                   proto_err,
    output logic [15:0]            drop_cnt
);

    localparam int             PTR_W    = $clog2(SKID_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(SKID_DEPTH);

    logic [7:0]             buf_data  [SKID_DEPTH];
    logic                   buf_start [SKID_DEPTH];
    logic                   buf_eop   [SKID_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;
    logic [PTR_W:0]         count_n;
    state_e                 state;
    state_e                 state_n;
    logic                   in_pkt;
    logic                   first_q;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   brk;
    logic                   head_start;
    logic                   head_eop;
    logic [7:0]             head_data;
    logic [NUM_CLASSES-1:0] rom_match;

    // in_pkt tracks framing on the input side, which can run ahead of the FSM by the buffered bytes.
    assign accept = s_valid & s_ready;
    assign push   = accept & (s_sop | in_pkt);
    assign drop   = accept & ~s_sop & ~in_pkt;
    assign brk    = accept & s_sop & in_pkt;

    assign head_data  = buf_data[rd_ptr];
    assign head_start = buf_start[rd_ptr];
    assign head_eop   = buf_eop[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr]  <= s_data;
            buf_start[wr_ptr] <= s_sop;
            buf_eop[wr_ptr]   <= s_eop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
        end
    end

    assign count_n = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

    // A start-marked head byte belongs to the current packet only right after its own SOD.
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        sod      = 1'b0;
        en       = 1'b0;
        pkt_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && s_sop) state_n = ST_SOD;
            end
            ST_SOD: begin
                sod     = 1'b1;
                state_n = ST_STREAM;
            end
            ST_STREAM: begin
                if (count != '0) begin
                    if (head_start && !first_q) begin
                        state_n = ST_DONE;
                    end else begin
                        pop = 1'b1;
                        en  = 1'b1;
                        if (head_eop) state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                pkt_done = 1'b1;
                state_n  = (count != '0) ? ST_SOD : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s_ready   <= 1'b0;
            in_pkt    <= 1'b0;
            first_q   <= 1'b0;
            proto_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_n;
            s_ready   <= (count_n != FULL_CNT) && (state_n == ST_IDLE || state_n == ST_STREAM);
            proto_err <= brk;
            if (state == ST_SOD) first_q <= 1'b1;
            else if (pop)        first_q <= 1'b0;
            if (accept) begin
                if (s_eop)      in_pkt <= 1'b0;
                else if (s_sop) in_pkt <= 1'b1;
            end
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    char_class_rom #(
        .NUM_CLASSES (NUM_CLASSES)
    ) u_rom (
        .data  (head_data),
        .match (rom_match)
    );

    assign char_match = en ? rom_match : '0;

endmodule

// File: tb/tb_char_block_decoder.sv
// tb/tb_char_block_decoder.sv - directed self-checking bench for char_block_decoder
module tb_char_block_decoder;

    localparam int NC   = 14;
    localparam int LOGN = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_sop;
    logic          s_eop;
    logic          sod;
    logic          en;
    logic [NC-1:0] char_match;
    logic          pkt_done;
    logic          proto_err;
    logic [15:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    char_block_decoder #(
        .NUM_CLASSES (NC),
        .SKID_DEPTH  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sop      (s_sop),
        .s_eop      (s_eop),
        .sod        (sod),
        .en         (en),
        .char_match (char_match),
        .pkt_done   (pkt_done),
        .proto_err  (proto_err),
        .drop_cnt   (drop_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } tx_t;

    typedef struct {
        logic [7:0]    d;
        logic [NC-1:0] cm;
    } vec_t;

    tx_t           txq[$];
    vec_t          vecs[$];
    logic [LOGN-1:0] lg_sod, lg_en, lg_done, lg_perr;
    logic [NC-1:0] lg_cm [LOGN];
    int            rel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic begin_test();
        txq.delete();
        lg_sod  = '0;
        lg_en   = '0;
        lg_done = '0;
        lg_perr = '0;
        for (int i = 0; i < LOGN; i++) lg_cm[i] = '0;
        rel = 0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++)
            txq.push_back(tx_t'{s[i], 1'(i == 0), 1'(i == s.len() - 1)});
    endtask

    // One call step: drive head of txq, sample outputs mid-cycle, advance past the next rising edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (txq.size() > 0) begin
                s_valid = 1'b1;
                s_data  = txq[0].d;
                s_sop   = txq[0].sop;
                s_eop   = txq[0].eop;
            end else begin
                s_valid = 1'b0;
                s_data  = 8'h00;
                s_sop   = 1'b0;
                s_eop   = 1'b0;
            end
            @(negedge clk);
            if (rel < LOGN) begin
                lg_sod[rel]  = sod;
                lg_en[rel]   = en;
                lg_done[rel] = pkt_done;
                lg_perr[rel] = proto_err;
                lg_cm[rel]   = char_match;
            end
            if (s_valid && s_ready) void'(txq.pop_front());
            @(posedge clk);
            #1;
            rel++;
        end
        s_valid = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_sop   = 1'b0;
        s_eop   = 1'b0;

        vecs.push_back(vec_t'{8'h61, 14'h0001});
        vecs.push_back(vec_t'{8'h41, 14'h0001});
        vecs.push_back(vec_t'{8'h44, 14'h0002});
        vecs.push_back(vec_t'{8'h76, 14'h0004});
        vecs.push_back(vec_t'{8'h4E, 14'h0008});
        vecs.push_back(vec_t'{8'h63, 14'h0010});
        vecs.push_back(vec_t'{8'h45, 14'h0020});
        vecs.push_back(vec_t'{8'h20, 14'h0040});
        vecs.push_back(vec_t'{8'h09, 14'h0040});
        vecs.push_back(vec_t'{8'h0A, 14'h0040});
        vecs.push_back(vec_t'{8'h0B, 14'h0040});
        vecs.push_back(vec_t'{8'h0C, 14'h0040});
        vecs.push_back(vec_t'{8'h0D, 14'h0040});
        vecs.push_back(vec_t'{8'h53, 14'h0080});
        vecs.push_back(vec_t'{8'h70, 14'h0100});
        vecs.push_back(vec_t'{8'h59, 14'h0200});
        vecs.push_back(vec_t'{8'h72, 14'h0400});
        vecs.push_back(vec_t'{8'h4F, 14'h0800});
        vecs.push_back(vec_t'{8'h74, 14'h1000});
        vecs.push_back(vec_t'{8'h46, 14'h2000});
        vecs.push_back(vec_t'{8'h7A, 14'h0000});
        vecs.push_back(vec_t'{8'h62, 14'h0000});
        vecs.push_back(vec_t'{8'hC1, 14'h0000});
        vecs.push_back(vec_t'{8'h40, 14'h0000});
        vecs.push_back(vec_t'{8'h5B, 14'h0000});
        vecs.push_back(vec_t'{8'h60, 14'h0000});
        vecs.push_back(vec_t'{8'h0E, 14'h0000});
        vecs.push_back(vec_t'{8'h08, 14'h0000});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {s_ready, sod, en, pkt_done, proto_err, char_match, drop_cnt}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", s_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("ready_after_release", s_ready, 1'b1);

        // Bytes without sop while idle are dropped and never reach the engine.
        begin_test();
        txq.push_back(tx_t'{8'h41, 1'b0, 1'b0});
        txq.push_back(tx_t'{8'h62, 1'b0, 1'b0});
        txq.push_back(tx_t'{8'h63, 1'b0, 1'b0});
        run_cycles(6);
        chk("drop_cnt", drop_cnt, 16'd3);
        chk("drop_no_sod", $countones(lg_sod), 0);
        chk("drop_no_en", $countones(lg_en), 0);

        // Single sop+eop byte packets: sod, one en with the class, pkt_done.
        foreach (vecs[v]) begin
            begin_test();
            txq.push_back(tx_t'{vecs[v].d, 1'b1, 1'b1});
            run_cycles(5);
            chk($sformatf("cm_%02h", vecs[v].d), lg_cm[2], vecs[v].cm);
            chk($sformatf("timing_%02h", vecs[v].d),
                {lg_sod[4:1], lg_en[4:1], lg_done[4:1], 32'($countones(lg_en))},
                {4'b0001, 4'b0010, 4'b0100, 32'd1});
        end

        begin_test();
        push_str("Advanced Spy Report for");
        run_cycles(30);
        chk("str_sod_at_1", lg_sod[1], 1'b1);
        chk("str_sod_count", $countones(lg_sod), 1);
        chk("str_en_window", lg_en[24:2], 23'h7FFFFF);
        chk("str_en_count", $countones(lg_en), 23);
        chk("str_done_at_25", lg_done[25], 1'b1);
        chk("str_done_count", $countones(lg_done), 1);
        chk("str_cm_first", lg_cm[2], 14'h0001);
        chk("str_cm_d", lg_cm[3], 14'h0002);
        chk("str_cm_space", lg_cm[10], 14'h0040);
        chk("str_cm_S", lg_cm[11], 14'h0080);
        chk("str_cm_last_r", lg_cm[24], 14'h0400);
        chk("str_no_perr", $countones(lg_perr), 0);

        begin_test();
        txq.push_back(tx_t'{8'h09, 1'b1, 1'b0});
        txq.push_back(tx_t'{8'h7A, 1'b0, 1'b0});
        txq.push_back(tx_t'{8'h53, 1'b0, 1'b1});
        run_cycles(8);
        chk("seq3_en", lg_en[5:2], 4'b0111);
        chk("seq3_cm0", lg_cm[2], 14'h0040);
        chk("seq3_cm1", lg_cm[3], 14'h0000);
        chk("seq3_cm2", lg_cm[4], 14'h0080);
        chk("seq3_done", lg_done[5], 1'b1);

        // New sop after 4 bytes: old packet closes, the sop byte opens the next one.
        begin_test();
        txq.push_back(tx_t'{8'h41, 1'b1, 1'b0});
        txq.push_back(tx_t'{8'h64, 1'b0, 1'b0});
        txq.push_back(tx_t'{8'h76, 1'b0, 1'b0});
        txq.push_back(tx_t'{8'h6E, 1'b0, 1'b0});
        txq.push_back(tx_t'{8'h63, 1'b1, 1'b0});
        txq.push_back(tx_t'{8'h65, 1'b0, 1'b1});
        run_cycles(16);
        chk("brk_perr_count", $countones(lg_perr), 1);
        chk("brk_en_first4", lg_en[6:2], 5'b01111);
        chk("brk_done_after_4th", lg_done[7], 1'b1);
        chk("brk_sod_new", lg_sod[8], 1'b1);
        chk("brk_new_byte_en", lg_en[9], 1'b1);
        chk("brk_new_byte_cm", lg_cm[9], 14'h0010);
        chk("brk_last_cm", lg_cm[10], 14'h0020);
        chk("brk_done2", lg_done[11], 1'b1);
        chk("brk_counts", {32'($countones(lg_en)), 32'($countones(lg_done))}, {32'd6, 32'd2});
        chk("brk_sod_count", $countones(lg_sod), 2);

        // Reset during the fifth en of a ten-byte packet.
        begin_test();
        push_str("abcdefghij");
        run_cycles(6);
        @(negedge clk);
        chk("rst_fifth_en", {en, char_match}, {1'b1, 14'h0020});
        chk("rst_prior_en_count", $countones(lg_en), 4);
        rst_n = 1'b0;
        txq.delete();
        s_valid = 1'b0;
        #1;
        chk("rst_outputs_zero", {s_ready, sod, en, pkt_done, proto_err, char_match, drop_cnt}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_hold_%0d", i), {sod, en, pkt_done, proto_err, s_ready}, 5'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        begin_test();
        txq.push_back(tx_t'{8'h61, 1'b1, 1'b1});
        run_cycles(5);
        chk("restart_timing", {lg_sod[4:1], lg_en[4:1], lg_done[4:1]}, {4'b0001, 4'b0010, 4'b0100});
        chk("restart_cm", lg_cm[2], 14'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_block_decoder.md
CHAR_BLOCK_DECODER -- requirements
Module: char_block_decoder

Interface
REQ-001 Parameter NUM_CLASSES, default 14; number of character-class match lines driven to the engine.
REQ-002 Parameter SKID_DEPTH, default 2; byte-buffer entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s_valid  input  1  upstream byte valid.
REQ-006 s_ready  output  1  decoder can accept a byte; registered.
REQ-007 s_data  input  8  payload byte.
REQ-008 s_sop  input  1  byte is first of a packet.
REQ-009 s_eop  input  1  byte is last of a packet.
REQ-010 sod  output  1  start-of-data pulse to the engine; clears its state flops.
REQ-011 en  output  1  engine step enable; high for exactly one cycle per delivered byte.
REQ-012 char_match  output  NUM_CLASSES  bit k drives engine input in_0_k.
REQ-013 pkt_done  output  1  one-cycle pulse; the engine result for the packet is final.
REQ-014 proto_err  output  1  one-cycle pulse on a framing violation.
REQ-015 drop_cnt  output  16  count of bytes discarded outside a packet; saturating.

Function
REQ-016 A byte SHALL be accepted when s_valid and s_ready are both high on a rising edge.
REQ-017 s_ready SHALL be low only when the skid buffer is full, or when a SOD or DONE cycle is pending.
REQ-018 The FSM SHALL have four states: IDLE, SOD, STREAM and DONE.
REQ-019 Transition IDLE->SOD SHALL occur on an accepted byte with s_sop=1.
REQ-020 While in IDLE, accepted bytes with s_sop=0 SHALL be dropped and SHALL increment drop_cnt, saturating at 0xFFFF.
REQ-021 The SOD state SHALL last exactly one cycle, with sod=1 and en=0, then move to STREAM.
REQ-022 In STREAM, with the buffer non-empty, the decoder SHALL pop one byte per cycle, driving en=1 and the decoded char_match in that same cycle.
REQ-023 In STREAM with the buffer empty, en SHALL be 0 and char_match SHALL be all-zero, so the engine holds its state.
REQ-024 Class decode SHALL be case-insensitive for letters.
REQ-025 Class mapping: 0 A, 1 d, 2 v, 3 n, 4 c, 5 e, 7 S, 8 p, 9 y, 10 R, 11 o, 12 t, 13 f.
REQ-026 Class 6 SHALL match 0x20, 0x09, 0x0A, 0x0B, 0x0C and 0x0D.
REQ-027 More than one char_match bit SHALL never be high for any single byte.
REQ-028 Once the s_eop byte is popped with en=1, the next cycle SHALL be DONE with pkt_done=1, then IDLE.
REQ-029 A byte carrying both s_sop and s_eop SHALL produce SOD, one en cycle, then DONE.
REQ-030 An accepted s_sop byte while in STREAM SHALL:
- pulse proto_err;
- close the current packet via DONE after the buffered bytes ahead of it drain;
- enter SOD for the new packet, with no byte lost.
REQ-031 Latency SHALL be fixed: the first byte of a packet accepted at cycle t shall see sod at t+1 and en at t+2 when not stalled.
REQ-032 Latency SHALL be fixed: a subsequent byte accepted at cycle t shall see en at t+1 earliest.
REQ-033 Sustained throughput SHALL be one byte per cycle within a packet.
REQ-034 The only inter-packet overhead SHALL be one SOD cycle and one DONE cycle.
REQ-035 Buffer pointers SHALL wrap modulo SKID_DEPTH.
REQ-036 Simultaneous push and pop when full SHALL NOT be permitted, since s_ready is low when full.
REQ-037 Simultaneous push and pop when empty SHALL NOT bypass the buffer.

Reset
REQ-038 While rst_n is low, the FSM SHALL be IDLE and the buffer empty.
REQ-039 While rst_n is low, s_ready, sod, en, char_match, pkt_done and proto_err SHALL be 0, and drop_cnt SHALL be 0.
REQ-040 Reset asserted mid-packet SHALL discard buffered bytes without emitting pkt_done.
REQ-041 s_ready SHALL rise on the first clock edge after rst_n deasserts.

Structure
REQ-042 A shared package SHALL hold the FSM state enum, the class-index constants and the whitespace byte constants.
REQ-043 A single sub-module, char_class_rom, SHALL map 8-bit data to NUM_CLASSES bits combinationally.
REQ-044 The skid buffer SHALL be inline in the top module.

Verification
REQ-045 Bytes "Advanced Spy Report for" sent as one packet with no stalls -> sod at cycle 1, 23 consecutive en pulses from cycle 2, pkt_done at cycle 25, first char_match=0x0001.
REQ-046 Single byte 0x61 with sop=eop=1 -> sod, one en with char_match=0x0001, then pkt_done the next cycle.
REQ-047 Bytes 0x09, 0x7A, 0x53 -> char_match values 0x0040, 0x0000, 0x0080.
REQ-048 Three bytes with sop=0 while IDLE -> drop_cnt=3, no sod and no en.
REQ-049 An s_sop byte arriving mid-packet after 4 bytes -> proto_err pulse, pkt_done after the 4th en, then sod, with the new byte delivered.
REQ-050 rst_n pulled low during the 5th en of a 10-byte packet -> all outputs 0, no pkt_done, clean restart on the next sop.
